// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the controller state encoding and the default halt opcode.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALTED
    } fetch_state_t;

    localparam logic [15:0] DEFAULT_HALT_INSTR = 16'hFFFF;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {address, instruction} pairs with a flush input.
// The head entry is presented combinationally; count reports occupancy.
module fetch_fifo #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [ADDR_WIDTH-1:0]     push_addr,
    input  logic [INSTR_WIDTH-1:0]    push_instr,
    input  logic                      pop,
    output logic [ADDR_WIDTH-1:0]     head_addr,
    output logic [INSTR_WIDTH-1:0]    head_instr,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0]  addr_mem  [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    // Storage is cleared on reset so the head reads as zero out of reset;
    // a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr]  <= push_addr;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_addr  = addr_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives pc inc/jmp, pairs RAM words with their
// addresses, buffers them and hands them to the decoder over valid/ready.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     FIFO_DEPTH  = 2,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = DEFAULT_HALT_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_inc,
    output logic                   pc_jmp,
    output logic [ADDR_WIDTH-1:0]  pc_addrin,
    input  logic [INSTR_WIDTH-1:0] mem_dout,
    input  logic                   redir_valid,
    input  logic [ADDR_WIDTH-1:0]  redir_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic                   halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic [CW:0]           limit;
    logic                  pop;
    logic                  push;
    logic                  push_halt;
    logic                  issue;

    fetch_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir_valid),
        .push      (push),
        .push_addr (inflight_addr),
        .push_instr(mem_dout),
        .pop       (pop),
        .head_addr (instr_addr),
        .head_instr(instr),
        .count     (count)
    );

    // A fetch is only issued when the word it returns is guaranteed a FIFO
    // slot, counting the word already in flight and any slot freed this cycle.
    always_comb begin
        instr_valid = (count != '0) && !redir_valid;
        pop         = instr_valid && instr_ready;
        push        = inflight && !redir_valid;
        push_halt   = push && (mem_dout == HALT_INSTR);
        occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
        limit       = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
        issue       = (state == FETCH) && run && !redir_valid && (occupancy < limit);
        pc_inc      = issue;
        pc_jmp      = redir_valid;
        pc_addrin   = redir_valid ? redir_addr : '0;
        halted      = (state == HALTED);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (run) next_state = FETCH;
            end
            FETCH: begin
                if (push_halt)  next_state = HALTED;
                else if (!run)  next_state = IDLE;
            end
            HALTED: begin
                if (redir_valid) next_state = run ? FETCH : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A word issued alongside the halt push is dropped when it returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            state    <= next_state;
            inflight <= issue && !push_halt;
            if (issue) begin
                inflight_addr <= pc_addr;
            end
        end
    end

endmodule
